// File: rtl/dbg_bus_master.sv
// Debug bus master: converts one host request at a time into a bus command,
// waits for accept and read response, and reports status with timeouts.
module dbg_bus_master #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic [1:0] rsp_err,
    output logic       busy,
    output logic [2:0] bus_MCmd,
    output logic [7:0] bus_MAddr,
    output logic [7:0] bus_MData,
    input  logic       bus_SCmdAccept,
    input  logic [7:0] bus_SData,
    input  logic [1:0] bus_SResp
);

    typedef enum logic [1:0] {S_IDLE, S_CMD, S_RESP} state_t;

    localparam logic [2:0] MCMD_IDLE  = 3'b000;
    localparam logic [2:0] MCMD_WR    = 3'b001;
    localparam logic [2:0] MCMD_RD    = 3'b010;
    localparam logic [1:0] SRESP_NULL = 2'b00;
    localparam logic [1:0] SRESP_DVA  = 2'b01;
    localparam logic [1:0] ERR_OK     = 2'b00;
    localparam logic [1:0] ERR_SLAVE  = 2'b01;
    localparam logic [1:0] ERR_ACC_TO = 2'b10;
    localparam logic [1:0] ERR_RSP_TO = 2'b11;
    // Last waiting cycle index: the wait ends when the count would reach the limit.
    localparam logic [7:0] CNT_LAST   = 8'(TIMEOUT_CYCLES - 1);

    state_t     state_q;
    logic [7:0] cnt_q;
    logic [2:0] mcmd_q;
    logic [7:0] maddr_q;
    logic [7:0] mdata_q;
    logic       rsp_valid_q;
    logic [7:0] rsp_data_q;
    logic [1:0] rsp_err_q;

    // Single FSM; every output is registered so completion lands one cycle after the event.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 8'd0;
            mcmd_q      <= MCMD_IDLE;
            maddr_q     <= 8'd0;
            mdata_q     <= 8'd0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'd0;
            rsp_err_q   <= ERR_OK;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        maddr_q <= req_addr;
                        mdata_q <= req_wdata;
                        mcmd_q  <= req_write ? MCMD_WR : MCMD_RD;
                        cnt_q   <= 8'd0;
                        state_q <= S_CMD;
                    end
                end
                S_CMD: begin
                    if (bus_SCmdAccept) begin
                        mcmd_q <= MCMD_IDLE;
                        cnt_q  <= 8'd0;
                        if (mcmd_q == MCMD_WR) begin
                            state_q     <= S_IDLE;
                            rsp_valid_q <= 1'b1;
                            rsp_data_q  <= 8'd0;
                            rsp_err_q   <= ERR_OK;
                        end else begin
                            state_q <= S_RESP;
                        end
                    end else if (cnt_q == CNT_LAST) begin
                        mcmd_q      <= MCMD_IDLE;
                        state_q     <= S_IDLE;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= 8'd0;
                        rsp_err_q   <= ERR_ACC_TO;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                S_RESP: begin
                    if (bus_SResp == SRESP_DVA) begin
                        state_q     <= S_IDLE;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= bus_SData;
                        rsp_err_q   <= ERR_OK;
                    end else if (bus_SResp != SRESP_NULL) begin
                        state_q     <= S_IDLE;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= 8'd0;
                        rsp_err_q   <= ERR_SLAVE;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q     <= S_IDLE;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= 8'd0;
                        rsp_err_q   <= ERR_RSP_TO;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign bus_MCmd  = mcmd_q;
    assign bus_MAddr = maddr_q;
    assign bus_MData = mdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dbg_bus_master.sv
// Randomized self-checking bench for dbg_bus_master: a reactive bus slave plus
// a transaction-level reference model predicting status, data and latency.
module tb_dbg_bus_master;

    localparam int T = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       req_valid;
    logic       req_ready;
    logic       req_write;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic [1:0] rsp_err;
    logic       busy;
    logic [2:0] bus_MCmd;
    logic [7:0] bus_MAddr;
    logic [7:0] bus_MData;
    logic       bus_SCmdAccept;
    logic [7:0] bus_SData;
    logic [1:0] bus_SResp;

    int checks = 0;
    int errors = 0;

    logic [7:0] slaveMem [256];
    logic [7:0] refMem   [256];

    dbg_bus_master #(.TIMEOUT_CYCLES(T)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_data       (rsp_data),
        .rsp_err        (rsp_err),
        .busy           (busy),
        .bus_MCmd       (bus_MCmd),
        .bus_MAddr      (bus_MAddr),
        .bus_MData      (bus_MData),
        .bus_SCmdAccept (bus_SCmdAccept),
        .bus_SData      (bus_SData),
        .bus_SResp      (bus_SResp)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Transaction-level prediction: outcome and cycle of rsp_valid counted from the handshake cycle.
    task automatic modelTxn(input logic w, input logic [7:0] a, input logic [7:0] d,
                            input int acc, input int rdel, input logic [1:0] code,
                            output int expLat, output int expCmd,
                            output logic [1:0] expErr, output logic [7:0] expData);
        if (acc >= T) begin
            expErr = 2'b10; expData = 8'h00; expCmd = T; expLat = T + 1;
        end else if (w) begin
            expErr = 2'b00; expData = 8'h00; expCmd = acc + 1; expLat = acc + 2;
            refMem[a] = d;
        end else if (rdel >= T) begin
            expErr = 2'b11; expData = 8'h00; expCmd = acc + 1; expLat = acc + 2 + T;
        end else begin
            expCmd = acc + 1; expLat = acc + rdel + 3;
            if (code == 2'b01) begin
                expErr = 2'b00; expData = refMem[a];
            end else begin
                expErr = 2'b01; expData = 8'h00;
            end
        end
    endtask

    task automatic applyStimulus(input logic w, input logic [7:0] a, input logic [7:0] d,
                                 input int acc, input int rdel, input logic [1:0] code);
        int expLat, expCmd;
        logic [1:0] expErr;
        logic [7:0] expData;
        int lat = 0;
        int cmdAny = 0;
        int cmdGood = 0;
        int respIdx = 0;
        bit accepted = 0;
        bit respActive = 0;
        bit sawCmd = 0;
        logic [7:0] firstAddr = 8'h00;
        logic [7:0] firstData = 8'h00;
        logic [1:0] gotErr = 2'b00;
        logic [7:0] gotData = 8'h00;
        logic [2:0] wantCmd;
        wantCmd = w ? 3'b001 : 3'b010;
        modelTxn(w, a, d, acc, rdel, code, expLat, expCmd, expErr, expData);
        @(negedge clk);
        checkOutput("idle_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
        bus_SCmdAccept = 1'b0; bus_SResp = 2'b00;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
            req_write = 1'($urandom);
            req_addr  = 8'($urandom);
            req_wdata = 8'($urandom);
            if (rsp_valid) begin
                lat = k; gotErr = rsp_err; gotData = rsp_data;
                break;
            end
            bus_SCmdAccept = 1'b0;
            bus_SResp = 2'b00;
            bus_SData = 8'($urandom);
            if (respActive) begin
                if (respIdx == rdel) begin
                    bus_SResp = code;
                    if (code == 2'b01) bus_SData = slaveMem[a];
                    respActive = 0;
                end
                respIdx++;
            end
            if (bus_MCmd != 3'b000 && !accepted) begin
                if (bus_MCmd == wantCmd) cmdGood++;
                if (!sawCmd) begin
                    firstAddr = bus_MAddr; firstData = bus_MData; sawCmd = 1;
                end
                bus_SResp = 2'($urandom);
                if (cmdAny == acc) begin
                    bus_SCmdAccept = 1'b1;
                    accepted = 1;
                    if (w) slaveMem[bus_MAddr] = bus_MData;
                    else begin
                        respActive = 1; respIdx = 0;
                    end
                end
                cmdAny++;
            end
        end
        bus_SCmdAccept = 1'b0;
        bus_SResp = 2'b00;
        checkOutput("rsp_latency", 32'(lat), 32'(expLat));
        checkOutput("rsp_err", 32'(gotErr), 32'(expErr));
        checkOutput("rsp_data", 32'(gotData), 32'(expData));
        checkOutput("mcmd_cycles", 32'(cmdGood), 32'(expCmd));
        checkOutput("maddr", 32'(firstAddr), 32'(a));
        checkOutput("mdata", 32'(firstData), 32'(d));
        @(negedge clk);
        checkOutput("rsp_single_pulse", 32'(rsp_valid), 32'd0);
        checkOutput("rsp_hold", 32'({rsp_err, rsp_data}), 32'({expErr, expData}));
        checkOutput("busy_after", 32'(busy), 32'd0);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_mcmd"}, 32'(bus_MCmd), 32'd0);
        checkOutput({tag, "_maddr"}, 32'(bus_MAddr), 32'd0);
        checkOutput({tag, "_mdata"}, 32'(bus_MData), 32'd0);
        checkOutput({tag, "_rsp"}, 32'({rsp_valid, rsp_err, rsp_data}), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_ready"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog observed=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int pulses;
        logic w;
        logic [7:0] a, d;
        logic [1:0] code;
        int acc, rdel;
        for (int i = 0; i < 256; i++) begin
            slaveMem[i] = 8'(i * 7 + 8'h44);
            refMem[i]   = 8'(i * 7 + 8'h44);
        end
        reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = 8'h00; req_wdata = 8'h00;
        bus_SCmdAccept = 1'b0; bus_SData = 8'h00; bus_SResp = 2'b00;
        repeat (3) @(negedge clk);
        checkResetOutputs("reset");
        reset_n = 1'b1;

        applyStimulus(1'b0, 8'h00, 8'h00, 0, 0, 2'b01);
        applyStimulus(1'b1, 8'h10, 8'hA5, 0, 0, 2'b01);
        applyStimulus(1'b0, 8'h10, 8'h3C, 0, 0, 2'b01);
        applyStimulus(1'b0, 8'h05, 8'h00, 7, 0, 2'b01);
        applyStimulus(1'b1, 8'h06, 8'h77, 3, 0, 2'b01);
        applyStimulus(1'b0, 8'h07, 8'h00, 1, 7, 2'b01);
        applyStimulus(1'b0, 8'h08, 8'h00, 0, 1, 2'b11);
        applyStimulus(1'b0, 8'h09, 8'h00, 3, 3, 2'b01);

        for (int n = 0; n < 40; n++) begin
            w    = 1'($urandom);
            a    = 8'($urandom_range(0, 15));
            d    = 8'($urandom);
            acc  = int'($urandom_range(0, 5));
            rdel = int'($urandom_range(0, 5));
            code = 2'($urandom_range(0, 3));
            if (code == 2'b00) code = 2'b01;
            applyStimulus(w, a, d, acc, rdel, code);
        end

        // Back-to-back writes with req_valid held high and an always-accepting slave.
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (rsp_valid) pulses++;
            if (k < 6) begin
                req_valid = 1'b1;
                req_write = 1'b1;
                if (k % 2 == 0) begin
                    req_addr  = 8'(8'h20 + k);
                    req_wdata = 8'($urandom);
                    refMem[req_addr] = req_wdata;
                end
                checkOutput("b2b_ready", 32'(req_ready), (k % 2 == 0) ? 32'd1 : 32'd0);
            end else begin
                req_valid = 1'b0;
            end
            bus_SResp = 2'b00;
            bus_SCmdAccept = (bus_MCmd == 3'b001);
            if (bus_SCmdAccept) slaveMem[bus_MAddr] = bus_MData;
        end
        bus_SCmdAccept = 1'b0;
        checkOutput("b2b_pulses", 32'(pulses), 32'd3);
        applyStimulus(1'b0, 8'h22, 8'h00, 0, 0, 2'b01);
        applyStimulus(1'b0, 8'h24, 8'h00, 1, 2, 2'b01);

        // Reset asserted while the read waits in RESP.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h31; req_wdata = 8'h5A;
        @(negedge clk);
        req_valid = 1'b0;
        bus_SCmdAccept = 1'b1;
        @(negedge clk);
        bus_SCmdAccept = 1'b0;
        checkOutput("mid_busy", 32'(busy), 32'd1);
        #2 reset_n = 1'b0;
        #1 checkResetOutputs("mid_reset");
        @(negedge clk);
        reset_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            bus_SResp = 2'b01;
            bus_SCmdAccept = 1'b1;
            @(negedge clk);
            if (rsp_valid) pulses++;
        end
        bus_SResp = 2'b00;
        bus_SCmdAccept = 1'b0;
        checkOutput("no_pulse_after_reset", 32'(pulses), 32'd0);
        applyStimulus(1'b0, 8'h00, 8'h00, 0, 0, 2'b01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
